// File: rtl/mem_pkg.sv
// Shared definitions for the memory arbiter: requester indices, the FSM
// state encoding and the round-robin index helper.
package mem_pkg;

  localparam int NREQ      = 3;
  localparam int REQ_FETCH = 0;
  localparam int REQ_LOAD  = 1;
  localparam int REQ_STORE = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2,
    ABORT   = 2'd3
  } state_t;

  // Requester index 'step' places after 'base', wrapping modulo NREQ.
  function automatic logic [1:0] rr_step(input logic [1:0] base, input int step);
    return 2'((int'(base) + step) % NREQ);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/grant bundle between the three memory FSMs and the arbiter.
// master: requester side; slave: arbiter side.
interface mem_arbiter_if;
  import mem_pkg::*;

  logic [NREQ-1:0] req;
  logic [NREQ-1:0] done_in;
  logic [NREQ-1:0] gnt;
  logic [1:0]      owner;
  logic            busy;
  logic            err;
  logic [1:0]      err_id;

  modport master (output req, done_in, input gnt, owner, busy, err, err_id);
  modport slave  (input req, done_in, output gnt, owner, busy, err, err_id);
endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner selection: the search starts at the index after
// ptr and wraps, so ptr==2 gives plain fixed priority bit0 > bit1 > bit2.
module mem_arb_pick
  import mem_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      ptr,
  output logic            valid,
  output logic [1:0]      index
);

  // Walk from the farthest candidate to the nearest so the nearest wins.
  always_comb begin
    valid = 1'b0;
    index = '0;
    for (int k = NREQ; k >= 1; k--) begin
      if (req[rr_step(ptr, k)]) begin
        valid = 1'b1;
        index = rr_step(ptr, k);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Memory arbiter for the fetch/load/store FSMs. One grant at a time,
// held until the owner's done pulse or until TO_CYC cycles elapse.
// Optional feature: define MEM_ARB_RR_EN for round-robin selection;
// otherwise selection is fixed priority (fetch > load > store).
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int TO_CYC = 16
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  localparam logic [7:0] HOLD_LAST = 8'(TO_CYC - 1);
  localparam logic [7:0] HOLD_MAX  = 8'hFF;

  state_t     state_reg, state_next;
  logic [1:0] owner_reg, owner_next;
  logic [7:0] hold_cnt_reg;
  logic [1:0] err_id_reg;
  logic [1:0] pick_ptr;
  logic       pick_valid;
  logic [1:0] pick_index;
  logic       timeout;

`ifdef MEM_ARB_RR_EN
  logic [1:0] rr_ptr_reg;

  // Remember the last winner; the next search starts just after it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      rr_ptr_reg <= 2'd2;
    else if (state_reg == IDLE && pick_valid)
      rr_ptr_reg <= pick_index;
  end

  assign pick_ptr = rr_ptr_reg;
`else
  // Pointer pinned at the last index makes the picker fixed priority.
  assign pick_ptr = 2'd2;
`endif

  mem_arb_pick u_pick (
    .req   (bus.req),
    .ptr   (pick_ptr),
    .valid (pick_valid),
    .index (pick_index)
  );

  assign timeout = (hold_cnt_reg >= HOLD_LAST);

  // State and owner registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      owner_reg <= '0;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
    end
  end

  // Next state: done beats timeout; owner is cleared on the way back to IDLE.
  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    case (state_reg)
      IDLE: begin
        if (pick_valid) begin
          state_next = GRANT;
          owner_next = pick_index;
        end
      end
      GRANT: begin
        if (bus.done_in[owner_reg])
          state_next = RELEASE;
        else if (timeout)
          state_next = ABORT;
      end
      RELEASE, ABORT: begin
        state_next = IDLE;
        owner_next = '0;
      end
      default: begin
        state_next = IDLE;
        owner_next = '0;
      end
    endcase
  end

  // Hold counter: zero outside GRANT, counts up while granted, saturates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      hold_cnt_reg <= '0;
    else if (state_reg != GRANT)
      hold_cnt_reg <= '0;
    else if (hold_cnt_reg != HOLD_MAX)
      hold_cnt_reg <= hold_cnt_reg + 8'd1;
  end

  // Capture the aborted owner as the FSM enters ABORT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      err_id_reg <= '0;
    else if (state_reg == GRANT && state_next == ABORT)
      err_id_reg <= owner_reg;
  end

  // Moore grant: one-hot of owner only while in GRANT.
  always_comb begin
    bus.gnt = '0;
    if (state_reg == GRANT)
      bus.gnt[owner_reg] = 1'b1;
  end

  assign bus.owner  = owner_reg;
  assign bus.busy   = (state_reg != IDLE);
  assign bus.err    = (state_reg == ABORT);
  assign bus.err_id = err_id_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: expected grant owners are queued
// when requests are driven and compared as grants appear.
module tb_mem_arbiter;

  localparam int TO = 6;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   exp_q[$];

  mem_arbiter_if bus ();

  mem_arbiter #(.TO_CYC(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.req = '0;
    bus.done_in = '0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (bus.gnt !== 3'b000 || bus.owner !== 2'd0 || bus.busy !== 1'b0 ||
        bus.err !== 1'b0 || bus.err_id !== 2'd0) begin
      n_bad++;
      $display("FAIL reset_state: gnt=%b owner=%0d busy=%b err=%b err_id=%0d, want 000/0/0/0/0",
               bus.gnt, bus.owner, bus.busy, bus.err, bus.err_id);
    end
  endtask

  task automatic test_basic();
    int exp_o;
    do_reset();
    bus.req = 3'b110;
    exp_q.push_back(1);
    step();
    exp_o = exp_q.pop_front();
    $display("grant: gnt=%b owner=%0d", bus.gnt, bus.owner);
    n_cmp++;
    if (bus.gnt !== 3'b010 || bus.owner !== 2'(exp_o)) begin
      n_bad++;
      $display("FAIL basic_grant: gnt=%b owner=%0d, want 010/%0d", bus.gnt, bus.owner, exp_o);
    end
    bus.done_in = 3'b010;
    bus.req = 3'b000;
    step();
    bus.done_in = 3'b000;
    n_cmp++;
    if (bus.gnt !== 3'b000 || bus.busy !== 1'b1) begin
      n_bad++;
      $display("FAIL basic_release: gnt=%b busy=%b, want 000/1", bus.gnt, bus.busy);
    end
    step();
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.owner !== 2'd0) begin
      n_bad++;
      $display("FAIL basic_idle: busy=%b owner=%0d, want 0/0", bus.busy, bus.owner);
    end
  endtask

  task automatic test_order();
    int exp_o;
    int wait_n;
    logic [2:0] exp_g;
    do_reset();
`ifdef MEM_ARB_RR_EN
    exp_q.push_back(0);
    exp_q.push_back(1);
    exp_q.push_back(2);
    exp_q.push_back(0);
`else
    exp_q.push_back(0);
    exp_q.push_back(0);
    exp_q.push_back(0);
`endif
    bus.req = 3'b111;
    while (exp_q.size() > 0) begin
      wait_n = 0;
      while (bus.gnt === 3'b000 && wait_n < 10) begin
        step();
        wait_n++;
      end
      exp_o = exp_q.pop_front();
      exp_g = 3'b000;
      exp_g[exp_o] = 1'b1;
      $display("grant: gnt=%b owner=%0d", bus.gnt, bus.owner);
      n_cmp++;
      if (bus.gnt !== exp_g || bus.owner !== 2'(exp_o)) begin
        n_bad++;
        $display("FAIL order_grant: gnt=%b owner=%0d, want %b/%0d", bus.gnt, bus.owner, exp_g, exp_o);
      end
      step();
      step();
      bus.done_in = bus.gnt;
      step();
      bus.done_in = 3'b000;
    end
    bus.req = 3'b000;
    step();
    step();
  endtask

  task automatic test_timeout();
    int exp_o;
    int cnt;
    do_reset();
    bus.req = 3'b100;
    exp_q.push_back(2);
    step();
    exp_o = exp_q.pop_front();
    $display("grant: gnt=%b owner=%0d", bus.gnt, bus.owner);
    n_cmp++;
    if (bus.owner !== 2'(exp_o)) begin
      n_bad++;
      $display("FAIL timeout_owner: owner=%0d, want %0d", bus.owner, exp_o);
    end
    bus.req = 3'b000;
    cnt = 0;
    while (bus.gnt === 3'b100 && cnt < 40) begin
      cnt++;
      step();
    end
    n_cmp++;
    if (cnt != TO) begin
      n_bad++;
      $display("FAIL timeout_len: held %0d cycles, want %0d", cnt, TO);
    end
    n_cmp++;
    if (bus.err !== 1'b1 || bus.err_id !== 2'd2 || bus.gnt !== 3'b000) begin
      n_bad++;
      $display("FAIL timeout_abort: err=%b err_id=%0d gnt=%b, want 1/2/000", bus.err, bus.err_id, bus.gnt);
    end
    step();
    n_cmp++;
    if (bus.err !== 1'b0 || bus.err_id !== 2'd2 || bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout_after: err=%b err_id=%0d busy=%b, want 0/2/0", bus.err, bus.err_id, bus.busy);
    end
  endtask

  task automatic test_done_timeout_tie();
    int exp_o;
    do_reset();
    bus.req = 3'b001;
    exp_q.push_back(0);
    step();
    exp_o = exp_q.pop_front();
    $display("grant: gnt=%b owner=%0d", bus.gnt, bus.owner);
    n_cmp++;
    if (bus.gnt !== 3'b001 || bus.owner !== 2'(exp_o)) begin
      n_bad++;
      $display("FAIL tie_grant: gnt=%b owner=%0d, want 001/%0d", bus.gnt, bus.owner, exp_o);
    end
    bus.req = 3'b000;
    for (int i = 0; i < TO - 1; i++) step();
    n_cmp++;
    if (bus.gnt !== 3'b001) begin
      n_bad++;
      $display("FAIL tie_held: gnt=%b, want 001", bus.gnt);
    end
    bus.done_in = 3'b001;
    step();
    bus.done_in = 3'b000;
    n_cmp++;
    if (bus.err !== 1'b0 || bus.busy !== 1'b1 || bus.gnt !== 3'b000) begin
      n_bad++;
      $display("FAIL tie_release: err=%b busy=%b gnt=%b, want 0/1/000", bus.err, bus.busy, bus.gnt);
    end
    step();
    n_cmp++;
    if (bus.err !== 1'b0 || bus.busy !== 1'b0 || bus.err_id !== 2'd0) begin
      n_bad++;
      $display("FAIL tie_idle: err=%b busy=%b err_id=%0d, want 0/0/0", bus.err, bus.busy, bus.err_id);
    end
  endtask

  task automatic test_ignore_and_async_reset();
    int exp_o;
    do_reset();
    bus.req = 3'b100;
    exp_q.push_back(2);
    step();
    exp_o = exp_q.pop_front();
    $display("grant: gnt=%b owner=%0d", bus.gnt, bus.owner);
    n_cmp++;
    if (bus.gnt !== 3'b100 || bus.owner !== 2'(exp_o)) begin
      n_bad++;
      $display("FAIL ignore_grant: gnt=%b owner=%0d, want 100/%0d", bus.gnt, bus.owner, exp_o);
    end
    bus.done_in = 3'b001;
    bus.req = 3'b000;
    step();
    bus.done_in = 3'b000;
    n_cmp++;
    if (bus.gnt !== 3'b100 || bus.owner !== 2'd2) begin
      n_bad++;
      $display("FAIL ignore_foreign_done: gnt=%b owner=%0d, want 100/2", bus.gnt, bus.owner);
    end
    step();
    n_cmp++;
    if (bus.gnt !== 3'b100) begin
      n_bad++;
      $display("FAIL ignore_req_drop: gnt=%b, want 100", bus.gnt);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (bus.gnt !== 3'b000 || bus.err !== 1'b0 || bus.busy !== 1'b0 || bus.owner !== 2'd0) begin
      n_bad++;
      $display("FAIL async_reset: gnt=%b err=%b busy=%b owner=%0d, want 000/0/0/0",
               bus.gnt, bus.err, bus.busy, bus.owner);
    end
    step();
    reset = 1'b0;
    step();
    n_cmp++;
    if (bus.err !== 1'b0 || bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_no_err: err=%b busy=%b, want 0/0", bus.err, bus.busy);
    end
  endtask

  initial begin
    bus.req = '0;
    bus.done_in = '0;
    test_reset();
    test_basic();
    test_order();
    test_timeout();
    test_done_timeout_tie();
    test_ignore_and_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter TO_CYC, default 16, giving the maximum cycles a grant may be held before it is aborted (legal range 2..255).
REQ-002 The block SHALL have port clk  input  1  system clock; all state changes on the rising edge.
REQ-003 The block SHALL have port reset  input  1  asynchronous active-high reset.
REQ-004 The block SHALL have port req  input  3  request levels: bit0 fetch FSM, bit1 Load FSM, bit2 Store FSM.
REQ-005 The block SHALL have port done_in  input  3  one-cycle done pulses from the same three FSMs, same bit order.
REQ-006 The block SHALL have port gnt  output  3  one-hot grant, used as the start input of the owning FSM; Moore output.
REQ-007 The block SHALL have port owner  output  2  index of the current grant holder; 0 when not busy.
REQ-008 The block SHALL have port busy  output  1  high in any state other than IDLE.
REQ-009 The block SHALL have port err  output  1  one-cycle pulse on a timeout abort.
REQ-010 The block SHALL have port err_id  output  2  index of the last aborted requester; holds until the next abort.

Function
REQ-011 The FSM SHALL have exactly four states: IDLE, GRANT, RELEASE and ABORT.
REQ-012 IDLE with any req bit set SHALL latch the winner into owner and go to GRANT on the next edge; IDLE with req==0 SHALL stay in IDLE.
REQ-013 gnt SHALL equal the one-hot of owner only in GRANT and SHALL be 0 in all other states.
REQ-014 Grant latency SHALL be one cycle: req seen in IDLE at edge n gives gnt high after edge n+1.
REQ-015 In GRANT, done_in[owner]==1 SHALL move the FSM to RELEASE; done_in bits of non-owners SHALL be ignored.
REQ-016 In GRANT, a 8-bit hold counter SHALL count cycles from 0; when it reaches TO_CYC-1 without done, the FSM SHALL go to ABORT.
REQ-017 If done_in[owner] and the timeout occur in the same cycle, done SHALL win and the FSM SHALL go to RELEASE.
REQ-018 Deassertion of req[owner] during GRANT SHALL be ignored; the grant holds until done or timeout.
REQ-019 RELEASE SHALL last one cycle with gnt=0 and then return to IDLE, so a back-to-back grant is possible at the earliest two cycles after done.
REQ-020 ABORT SHALL last one cycle with gnt=0, err=1 and err_id=owner, and then return to IDLE.
REQ-021 The hold counter SHALL clear on entry to GRANT and SHALL NOT wrap.
REQ-022 Without MEM_ARB_RR_EN, selection SHALL be fixed priority: bit0 > bit1 > bit2.

Reset
REQ-023 Reset SHALL force IDLE, gnt=0, owner=0, busy=0, err=0, err_id=0, hold counter=0 and RR pointer=2, immediately and independent of clk.
REQ-024 Reset asserted mid-grant SHALL drop gnt with no err pulse.

Configuration
REQ-025 With MEM_ARB_RR_EN defined, selection SHALL be round-robin: the search starts at the index after the RR pointer (2 wraps to 0), and the pointer takes the winner's index on every IDLE-to-GRANT transition.
REQ-026 With MEM_ARB_RR_EN undefined, the RR pointer SHALL NOT exist and REQ-022 SHALL apply.

Structure
REQ-027 Shared package mem_pkg SHALL hold NREQ=3, REQ_FETCH=0, REQ_LOAD=1, REQ_STORE=2 and the 2-bit state encoding (IDLE=0, GRANT=1, RELEASE=2, ABORT=3).
REQ-028 Winner selection SHALL live in one combinational sub-module, mem_arb_pick (inputs req and pointer; outputs valid and index), instantiated once.

Verification
REQ-029 req=3'b110 in IDLE -> gnt=3'b010 one cycle later and owner=1; done_in=3'b010 -> gnt=0 next cycle and busy=0 one cycle after that.
REQ-030 req=3'b111 held, each owner pulses done after 3 cycles -> without the macro the grant order is 0,0,0; with MEM_ARB_RR_EN it is 0,1,2,0.
REQ-031 req=3'b100 with no done -> gnt=3'b100 for exactly TO_CYC cycles, then err=1 for one cycle, err_id=2 and gnt=0.
REQ-032 Owner's done_in and the timeout in the same cycle -> RELEASE taken and err stays 0.
REQ-033 done_in=3'b001 while owner=2 -> ignored and the grant is held; reset pulsed in GRANT -> gnt=0 asynchronously and err=0.
